serial_slice_adder: RTL and testbench

SERIAL_SLICE_ADDER -- requirements
Module: serial_slice_adder

---
 rtl/serial_slice_adder.sv | 119 +++++++++++
 tb/tb_serial_slice_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slice_adder.sv
// Slice-serial adder: adds SLICE bits of the captured operands per cycle behind valid/ready handshakes.
// Optional signed-overflow output `ovf` is present when SERIAL_SLICE_ADDER_OVF_EN is defined.
module serial_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             out_valid_r;
  logic [IW-1:0]    idx_r;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  logic             ovf_r;
`endif

  logic [SLICE-1:0] a_sl_s;
  logic [SLICE-1:0] b_sl_s;
  logic [SLICE:0]   slice_sum_s;

  // Current slice of the captured operands plus the running carry.
  always_comb begin
    a_sl_s      = a_r[idx_r*SLICE +: SLICE];
    b_sl_s      = b_r[idx_r*SLICE +: SLICE];
    slice_sum_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_r};
  end

  // Control FSM together with the operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      idx_r       <= {IW{1'b0}};
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= {IW{1'b0}};
            state_r <= ADD;
          end
        end
        ADD: begin
          sum_r[idx_r*SLICE +: SLICE] <= slice_sum_s[SLICE-1:0];
          carry_r                     <= slice_sum_s[SLICE];
          if (idx_r == LAST_IDX) begin
            cout_r      <= slice_sum_s[SLICE];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
            // Carry into the MSB is recovered from a^b^sum at that bit.
            ovf_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ slice_sum_s[SLICE-1] ^ slice_sum_s[SLICE];
`endif
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == ADD) || (state_r == DONE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_slice_adder.sv
// Self-checking bench for serial_slice_adder: a 16/4 instance and an 8/8 instance,
// directed vector table, handshake/reset corner sequences and randomized sweeps against an arithmetic model.
module tb_serial_slice_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16, cin16, cout16, busy16;
  logic [15:0] a16, b16, sum16;
  logic        iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0]  a8, b8, sum8;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  logic        ovf16, ovf8;
`endif

  serial_slice_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16),
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .busy(busy16));

  serial_slice_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .busy(busy8));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Signed overflow from the definition: true sum outside the w-bit two's complement range.
  function automatic logic ovf_ref(input int w, input longint sa, input longint sb, input logic c);
    longint t;
    t = sa + sb + longint'(c);
    return (t > ((longint'(1) << (w - 1)) - 1)) || (t < -(longint'(1) << (w - 1)));
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[9];

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a16 = a; b16 = b; cin16 = c; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    iv16 = 1'b0;
    chk("busy16_after_accept", {31'd0, busy16}, 32'd1);
  endtask

  task automatic finish16(output logic [15:0] s, output logic c, output logic o, output int lat);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'($urandom);
    end
    s = sum16; c = cout16;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    o = ovf16;
`else
    o = 1'b0;
`endif
  endtask

  task automatic hs16();
    @(negedge clk);
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    chk("ov16_after_hs", {31'd0, ov16}, 32'd0);
    chk("ir16_after_hs", {31'd0, ir16}, 32'd1);
    or16 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic finish8(output logic [7:0] s, output logic c, output logic o, output int lat);
    lat = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
    end
    s = sum8; c = cout8;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    o = ovf8;
`else
    o = 1'b0;
`endif
  endtask

  task automatic hs8();
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    chk("ov8_after_hs", {31'd0, ov8}, 32'd0);
    or8 = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic [7:0]  s8;
    logic        c, o;
    int          lat, seen;
    logic [16:0] exp17;
    logic [8:0]  exp9;
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rc;

    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[2] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

    iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", {31'd0, ir16}, 32'd1);
    chk("rst_out_valid", {31'd0, ov16}, 32'd0);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_sum", {16'd0, sum16}, 32'd0);
    chk("rst_cout", {31'd0, cout16}, 32'd0);
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf16}, 32'd0);
`endif

    // First edge after reset release accepts operands.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; iv16 = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    chk("first_edge_accept_busy", {31'd0, busy16}, 32'd1);
    chk("first_edge_accept_ready", {31'd0, ir16}, 32'd0);
    finish16(s, c, o, lat);
    chk("first_edge_sum", {16'd0, s}, 32'h0100);
    chk("first_edge_lat", lat, 32'd4);
    hs16();

    for (int i = 0; i < 9; i++) begin
      start16(vecs[i].a, vecs[i].b, vecs[i].cin);
      finish16(s, c, o, lat);
      chk($sformatf("vec%0d_sum", i), {16'd0, s}, {16'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].c});
      chk($sformatf("vec%0d_lat", i), lat, 32'd4);
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].o});
`endif
      hs16();
    end

    // Backpressure: result held while in_valid keeps toggling operands.
    start16(16'h0F0F, 16'h00F1, 1'b0);
    finish16(s, c, o, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv16 = 1'b1; or16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", k), {31'd0, ov16}, 32'd1);
      chk($sformatf("bp%0d_sum", k), {16'd0, sum16}, 32'h1000);
      chk($sformatf("bp%0d_cout", k), {31'd0, cout16}, 32'd0);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, ir16}, 32'd0);
    end
    hs16();

    // Reset two ADD edges into an operation aborts it.
    start16(16'hBEEF, 16'h1111, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, ov16}, 32'd0);
    chk("abort_sum", {16'd0, sum16}, 32'd0);
    chk("abort_in_ready", {31'd0, ir16}, 32'd1);
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ov16 === 1'b1) seen++;
    end
    chk("abort_no_out_valid", seen, 32'd0);
    start16(16'h1234, 16'h1111, 1'b0);
    finish16(s, c, o, lat);
    chk("after_abort_sum", {16'd0, s}, 32'h2345);
    chk("after_abort_cout", {31'd0, c}, 32'd0);
    hs16();

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      exp17 = 17'(ra) + 17'(rb) + 17'(rc);
      start16(ra, rb, rc);
      finish16(s, c, o, lat);
      chk($sformatf("rnd16_%0d_sum", n), {15'd0, c, s}, {15'd0, exp17});
      chk($sformatf("rnd16_%0d_lat", n), lat, 32'd4);
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      chk($sformatf("rnd16_%0d_ovf", n), {31'd0, o},
          {31'd0, ovf_ref(16, longint'($signed(ra)), longint'($signed(rb)), rc)});
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      hs16();
    end

    start8(8'hF0, 8'h0F, 1'b1);
    finish8(s8, c, o, lat);
    chk("w8_sum", {24'd0, s8}, 32'h00);
    chk("w8_cout", {31'd0, c}, 32'd1);
    chk("w8_lat", lat, 32'd1);
    hs8();

    for (int n = 0; n < 1000; n++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      exp9 = 9'(ra8) + 9'(rb8) + 9'(rc);
      start8(ra8, rb8, rc);
      finish8(s8, c, o, lat);
      chk($sformatf("rnd8_%0d_sum", n), {23'd0, c, s8}, {23'd0, exp9});
      if (lat != 1) chk($sformatf("rnd8_%0d_lat", n), lat, 32'd1);
`ifdef SERIAL_SLICE_ADDER_OVF_EN
      chk($sformatf("rnd8_%0d_ovf", n), {31'd0, o},
          {31'd0, ovf_ref(8, longint'($signed(ra8)), longint'($signed(rb8)), rc)});
`endif
      hs8();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
